// File: rtl/parity_frame_rx_if.sv
// Serial receive bundle: bit input with qualifier, counter clear, and recovered-frame outputs.
// Latency: none (wires only).
// Backpressure: none; the bit stream is qualified by x_valid, not flow-controlled.
//
// slave  : the receiver (consumes x/x_valid/clr_cnt, drives results)
// master : the bit source / result consumer
interface parity_frame_rx_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
);
  logic              x;
  logic              x_valid;
  logic              clr_cnt;
  logic [DATA_W-1:0] data;
  logic              data_valid;
  logic              parity_err;
  logic              frame_err;
  logic [CNT_W-1:0]  err_count;
  logic              busy;

  modport slave (
    input  x, x_valid, clr_cnt,
    output data, data_valid, parity_err, frame_err, err_count, busy
  );

  modport master (
    output x, x_valid, clr_cnt,
    input  data, data_valid, parity_err, frame_err, err_count, busy
  );
endinterface

// File: rtl/parity_frame_rx.sv
// Serial frame receiver: start(0), DATA_W data bits LSB first, parity, stop(1); checks parity and stop.
// Latency: data_valid pulses for one cycle right after the stop-bit edge; results held until next frame.
// Backpressure: none; bits advance only on x_valid, a frame may stall indefinitely between bits.
//
// Ports: clk, rst_n (async active-low), rx (slave modport): x, x_valid, clr_cnt in;
//        data, data_valid, parity_err, frame_err, err_count (saturating), busy out.
//        The interface DATA_W/CNT_W must match this module's parameters.
module parity_frame_rx #(
  parameter int DATA_W     = 8,
  parameter int ODD_PARITY = 0,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  parity_frame_rx_if.slave      rx
);

  localparam int   BW      = $clog2(DATA_W + 1);
  localparam logic PAR_TGT = (ODD_PARITY != 0);

  typedef enum logic [1:0] {IDLE, DATA, PAR, STOP} state_t;

  state_t            state_q, state_d;
  logic [BW-1:0]     bitcnt_q;
  logic [DATA_W-1:0] shift_q;
  logic              par_q;
  logic [DATA_W-1:0] data_q;
  logic              data_valid_q;
  logic              parity_err_q;
  logic              frame_err_q;
  logic [CNT_W-1:0]  err_count_q;

  logic              done;       // stop bit accepted this edge
  logic              perr_next;
  logic              ferr_next;

  // par_q already includes the parity bit once we are in STOP
  assign perr_next = (par_q != PAR_TGT);
  assign ferr_next = ~rx.x;

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    if (rx.x_valid) begin
      case (state_q)
        IDLE: if (!rx.x) state_d = DATA;
        DATA: if (bitcnt_q == BW'(DATA_W - 1)) state_d = PAR;
        PAR:  state_d = STOP;
        STOP: begin
          // a 0 stop bit is a framing error, not a new start bit
          state_d = IDLE;
          done    = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bitcnt_q     <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      err_count_q  <= '0;
    end else begin
      data_valid_q <= done;
      if (rx.x_valid) begin
        case (state_q)
          IDLE: begin
            if (!rx.x) begin
              bitcnt_q <= '0;
              par_q    <= 1'b0;
            end
          end
          DATA: begin
            // decoded write keeps the index within DATA_W for any counter width
            for (int i = 0; i < DATA_W; i++) begin
              if (bitcnt_q == BW'(i)) shift_q[i] <= rx.x;
            end
            par_q    <= par_q ^ rx.x;
            bitcnt_q <= bitcnt_q + 1'b1;
          end
          PAR: begin
            par_q <= par_q ^ rx.x;
          end
          STOP: begin
            data_q       <= shift_q;
            parity_err_q <= perr_next;
            frame_err_q  <= ferr_next;
          end
          default: ;
        endcase
      end
      // clear wins over a same-edge increment
      if (rx.clr_cnt) begin
        err_count_q <= '0;
      end else if (done && (perr_next || ferr_next) && (err_count_q != {CNT_W{1'b1}})) begin
        err_count_q <= err_count_q + 1'b1;
      end
    end
  end

  assign rx.data       = data_q;
  assign rx.data_valid = data_valid_q;
  assign rx.parity_err = parity_err_q;
  assign rx.frame_err  = frame_err_q;
  assign rx.err_count  = err_count_q;
  assign rx.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_parity_frame_rx.sv
// Bench for parity_frame_rx: three instances (even/8-bit count, odd/8-bit count, even/2-bit count)
// share one bit stream; a vector table of frames plus hand sequences for stop-0, back-to-back and reset.
module tb_parity_frame_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic x;
  logic xv;
  logic clr;

  parity_frame_rx_if #(.DATA_W(8), .CNT_W(8)) if0 ();
  parity_frame_rx_if #(.DATA_W(8), .CNT_W(8)) if1 ();
  parity_frame_rx_if #(.DATA_W(8), .CNT_W(2)) if2 ();

  assign if0.x = x;  assign if0.x_valid = xv;  assign if0.clr_cnt = clr;
  assign if1.x = x;  assign if1.x_valid = xv;  assign if1.clr_cnt = clr;
  assign if2.x = x;  assign if2.x_valid = xv;  assign if2.clr_cnt = clr;

  parity_frame_rx #(.DATA_W(8), .ODD_PARITY(0), .CNT_W(8)) dut0 (.clk(clk), .rst_n(rst_n), .rx(if0));
  parity_frame_rx #(.DATA_W(8), .ODD_PARITY(1), .CNT_W(8)) dut1 (.clk(clk), .rst_n(rst_n), .rx(if1));
  parity_frame_rx #(.DATA_W(8), .ODD_PARITY(0), .CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .rx(if2));

  int n_tests = 0;
  int n_fail  = 0;
  int dv_total = 0;
  int busy_hits;

  always @(negedge clk) if (if0.data_valid) dv_total++;

  typedef struct {
    logic [7:0] d;
    logic       p;
    logic       s;
    logic       gaps;
    int         lead;
    logic       clr_before;
    logic       clr_on_stop;
    logic [7:0] e_data;
    logic       pe_e;
    logic       pe_o;
    logic       fe;
    logic [7:0] c0;
    logic [7:0] c1;
    logic [1:0] c2;
  } vec_t;

  vec_t vt [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic send_bit(input logic b, input logic c);
    x = b; xv = 1'b1; clr = c;
    @(posedge clk); #1;
    xv = 1'b0; clr = 1'b0;
  endtask

  task automatic gap();
    xv = 1'b0; x = ~x;
    @(posedge clk); #1;
  endtask

  task automatic note_busy();
    if (if0.busy) busy_hits++;
  endtask

  task automatic run_frame(input logic [7:0] d, input logic p, input logic s,
                           input logic g, input logic co);
    busy_hits = 0;
    send_bit(1'b0, 1'b0); note_busy();
    if (g) begin gap(); gap(); end
    for (int i = 0; i < 8; i++) begin
      send_bit(d[i], 1'b0); note_busy();
      if (g) begin gap(); gap(); end
    end
    send_bit(p, 1'b0); note_busy();
    if (g) begin gap(); gap(); end
    send_bit(s, co); note_busy();
  endtask

  initial begin
    int snap;
    vec_t v;
    //          d      p     s     gaps  lead clrb  clrs  e_data pe_e  pe_o  fe    c0     c1     c2
    vt[0]  = '{8'hA5, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 8'd0, 8'd1, 2'd0};
    vt[1]  = '{8'h01, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0, 8'd1, 8'd1, 2'd1};
    vt[2]  = '{8'h03, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 8'h03, 1'b0, 1'b1, 1'b1, 8'd2, 8'd2, 2'd2};
    vt[3]  = '{8'h3C, 1'b0, 1'b1, 1'b1, 2, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0, 8'd2, 8'd3, 2'd2};
    vt[4]  = '{8'h01, 1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0, 8'd1, 8'd0, 2'd1};
    vt[5]  = '{8'h01, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0, 8'd2, 8'd0, 2'd2};
    vt[6]  = '{8'h01, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0, 8'd3, 8'd0, 2'd3};
    vt[7]  = '{8'h01, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0, 8'd4, 8'd0, 2'd3};
    vt[8]  = '{8'h01, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0, 8'd5, 8'd0, 2'd3};
    vt[9]  = '{8'h01, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 2'd0};
    vt[10] = '{8'h01, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 8'h01, 1'b0, 1'b1, 1'b0, 8'd0, 8'd1, 2'd0};
    vt[11] = '{8'h01, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 1'b1, 8'd1, 8'd2, 2'd1};

    rst_n = 1'b0; x = 1'b1; xv = 1'b0; clr = 1'b0;
    #12;
    chk("rst_data",  32'(if0.data), 32'h0);
    chk("rst_dv",    32'(if0.data_valid), 32'h0);
    chk("rst_perr",  32'(if0.parity_err), 32'h0);
    chk("rst_ferr",  32'(if0.frame_err), 32'h0);
    chk("rst_cnt",   32'(if0.err_count), 32'h0);
    chk("rst_busy",  32'(if0.busy), 32'h0);
    chk("rst_cnt2",  32'(if2.err_count), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      v = vt[i];
      if (v.clr_before) begin
        clr = 1'b1; xv = 1'b0;
        @(posedge clk); #1;
        clr = 1'b0;
        chk($sformatf("v%0d_clr_c0", i), 32'(if0.err_count), 32'h0);
        chk($sformatf("v%0d_clr_c2", i), 32'(if2.err_count), 32'h0);
      end
      for (int k = 0; k < v.lead; k++) begin
        send_bit(1'b1, 1'b0);
        chk($sformatf("v%0d_idle_busy", i), 32'(if0.busy), 32'h0);
      end
      snap = dv_total;
      run_frame(v.d, v.p, v.s, v.gaps, v.clr_on_stop);
      chk($sformatf("v%0d_dv", i),    32'(if0.data_valid), 32'h1);
      chk($sformatf("v%0d_data", i),  32'(if0.data), 32'(v.e_data));
      chk($sformatf("v%0d_pe_e", i),  32'(if0.parity_err), 32'(v.pe_e));
      chk($sformatf("v%0d_pe_o", i),  32'(if1.parity_err), 32'(v.pe_o));
      chk($sformatf("v%0d_fe", i),    32'(if0.frame_err), 32'(v.fe));
      chk($sformatf("v%0d_c0", i),    32'(if0.err_count), 32'(v.c0));
      chk($sformatf("v%0d_c1", i),    32'(if1.err_count), 32'(v.c1));
      chk($sformatf("v%0d_c2", i),    32'(if2.err_count), 32'(v.c2));
      chk($sformatf("v%0d_busy", i),  32'(busy_hits), 32'd10);
      gap();
      chk($sformatf("v%0d_dv_end", i), 32'(if0.data_valid), 32'h0);
      chk($sformatf("v%0d_dv_cnt", i), 32'(dv_total - snap), 32'd1);
    end

    // stop bit 0: framing error, then an accepted 1 must not start a frame
    run_frame(8'h03, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("s0_ferr", 32'(if0.frame_err), 32'h1);
    chk("s0_perr", 32'(if0.parity_err), 32'h0);
    chk("s0_c0",   32'(if0.err_count), 32'd2);
    send_bit(1'b1, 1'b0);
    chk("s0_busy1", 32'(if0.busy), 32'h0);
    send_bit(1'b1, 1'b0);
    chk("s0_busy2", 32'(if0.busy), 32'h0);
    chk("s0_dv",    32'(if0.data_valid), 32'h0);

    // back-to-back frames: start bit on the edge right after the stop bit
    run_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("b2b_dv1", 32'(if0.data_valid), 32'h1);
    send_bit(1'b0, 1'b0);
    chk("b2b_busy", 32'(if0.busy), 32'h1);
    chk("b2b_hold", 32'(if0.data), 32'hA5);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] w;
      w = 8'h5A;
      send_bit(w[i], 1'b0);
    end
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    chk("b2b_dv2",  32'(if0.data_valid), 32'h1);
    chk("b2b_data", 32'(if0.data), 32'h5A);
    chk("b2b_perr", 32'(if0.parity_err), 32'h0);
    chk("b2b_c0",   32'(if0.err_count), 32'd2);
    gap();

    // asynchronous reset mid-frame after 4 data bits
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    chk("mr_busy_pre", 32'(if0.busy), 32'h1);
    #3 rst_n = 1'b0;
    #1;
    chk("mr_data", 32'(if0.data), 32'h0);
    chk("mr_busy", 32'(if0.busy), 32'h0);
    chk("mr_cnt",  32'(if0.err_count), 32'h0);
    chk("mr_ferr", 32'(if0.frame_err), 32'h0);
    chk("mr_perr", 32'(if0.parity_err), 32'h0);
    chk("mr_dv",   32'(if0.data_valid), 32'h0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    run_frame(8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("mr_f_dv",   32'(if0.data_valid), 32'h1);
    chk("mr_f_data", 32'(if0.data), 32'h5A);
    chk("mr_f_perr", 32'(if0.parity_err), 32'h0);
    chk("mr_f_ferr", 32'(if0.frame_err), 32'h0);
    chk("mr_f_c0",   32'(if0.err_count), 32'h0);
    chk("mr_f_c2",   32'(if2.err_count), 32'h0);
    gap();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
